contactor_sequencer: RTL and testbench

CONTACTOR_SEQUENCER -- requirements
Module: contactor_sequencer

---
 rtl/spi_pkg.sv | 17 +
 rtl/rr_picker.sv | 32 +++
 rtl/contactor_sequencer.sv | 125 ++++++++++++
 tb/tb_contactor_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants for the contactor sequencer
package spi_pkg;

    localparam int NUM_CH_DEFAULT = 21;

    localparam logic [1:0] FB_OPEN   = 2'b01;
    localparam logic [1:0] FB_CLOSED = 2'b10;

    // Sequencer state encoding
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SELECT  = 3'd1;
    localparam logic [2:0] ST_DRIVE   = 3'd2;
    localparam logic [2:0] ST_WAIT_FB = 3'd3;
    localparam logic [2:0] ST_SETTLE  = 3'd4;
    localparam logic [2:0] ST_FAULT   = 3'd5;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - round-robin first-set picker starting at a given index
module rr_picker
    import spi_pkg::*;
#(
    parameter int N = NUM_CH_DEFAULT
) (
    input  logic [N-1:0] mask,
    input  logic [4:0]   start,
    output logic         valid,
    output logic [4:0]   idx
);

    logic [5:0] cand;

    // Scan offsets from the far end down so the nearest hit to start wins.
    always_comb begin
        valid = 1'b0;
        idx   = 5'd0;
        cand  = 6'd0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = {1'b0, start} + 6'(i);
            if (cand >= 6'(N)) begin
                cand = cand - 6'(N);
            end
            if (mask[cand[4:0]]) begin
                valid = 1'b1;
                idx   = cand[4:0];
            end
        end
    end

endmodule

// File: rtl/contactor_sequencer.sv
// rtl/contactor_sequencer.sv - one-at-a-time contactor sequencer with feedback timeout
module contactor_sequencer
    import spi_pkg::*;
#(
    parameter int NUM_CH      = NUM_CH_DEFAULT,
    parameter int TIMEOUT_CYC = 200,
    parameter int SETTLE_CYC  = 4
) (
    input  logic                sclk,
    input  logic                rst_n,
    input  logic [NUM_CH-1:0]   req_i,
    input  logic [2*NUM_CH-1:0] feedback_i,
    input  logic                shutdown_i,
    input  logic                clear_errors_i,
    output logic [NUM_CH-1:0]   cmd_o,
    output logic                busy_o,
    output logic [4:0]          active_ch_o,
    output logic                timeout_err_o,
    output logic [4:0]          err_ch_o
);

    logic [2:0]        state;
    logic [7:0]        timer;
    logic [4:0]        last_ch;
    logic [4:0]        ch;
    logic              target;
    logic [4:0]        start_ch;
    logic [4:0]        pick_idx;
    logic              pick_valid;
    logic [NUM_CH-1:0] open_mask;
    logic [NUM_CH-1:0] close_mask;
    logic [NUM_CH-1:0] pick_mask;
    logic [1:0]        ch_fb;
    logic              fb_match;

    // Opening a contactor always takes precedence over closing one.
    assign open_mask  = cmd_o & ~req_i;
    assign close_mask = req_i & ~cmd_o;
    assign pick_mask  = (|open_mask) ? open_mask : close_mask;
    assign start_ch   = (last_ch == 5'(NUM_CH - 1)) ? 5'd0 : last_ch + 5'd1;

    rr_picker #(.N(NUM_CH)) u_picker (
        .mask  (pick_mask),
        .start (start_ch),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign ch_fb    = feedback_i[{ch, 1'b0} +: 2];
    assign fb_match = target ? (ch_fb == FB_CLOSED) : (ch_fb == FB_OPEN);

    assign busy_o      = (state != ST_IDLE);
    assign active_ch_o = (state == ST_DRIVE || state == ST_WAIT_FB || state == ST_SETTLE) ? ch : 5'd0;

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cmd_o         <= '0;
            timer         <= 8'd0;
            last_ch       <= 5'(NUM_CH - 1);
            ch            <= 5'd0;
            target        <= 1'b0;
            timeout_err_o <= 1'b0;
            err_ch_o      <= 5'd0;
        end else if (shutdown_i) begin
            state <= ST_IDLE;
            cmd_o <= '0;
            timer <= 8'd0;
            if (clear_errors_i) begin
                timeout_err_o <= 1'b0;
                err_ch_o      <= 5'd0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_i != cmd_o) begin
                        state <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (pick_valid) begin
                        ch     <= pick_idx;
                        target <= req_i[pick_idx];
                        state  <= ST_DRIVE;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_DRIVE: begin
                    cmd_o[ch] <= target;
                    timer     <= 8'd0;
                    state     <= ST_WAIT_FB;
                end
                ST_WAIT_FB: begin
                    timer <= timer + 8'd1;
                    if (fb_match) begin
                        timer <= 8'd0;
                        state <= ST_SETTLE;
                    end else if (timer == 8'(TIMEOUT_CYC - 1)) begin
                        cmd_o[ch]     <= 1'b0;
                        timeout_err_o <= 1'b1;
                        err_ch_o      <= ch;
                        state         <= ST_FAULT;
                    end
                end
                ST_SETTLE: begin
                    timer <= timer + 8'd1;
                    if (timer == 8'(SETTLE_CYC - 1)) begin
                        last_ch <= ch;
                        state   <= ST_IDLE;
                    end
                end
                ST_FAULT: begin
                    if (clear_errors_i) begin
                        timeout_err_o <= 1'b0;
                        err_ch_o      <= 5'd0;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_contactor_sequencer.sv
// tb/tb_contactor_sequencer.sv - self-checking bench for contactor_sequencer
module tb_contactor_sequencer;

    localparam int N  = 21;
    localparam int TO = 200;
    localparam int ST = 4;

    logic          sclk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req_i;
    logic [2*N-1:0] feedback_i;
    logic          shutdown_i;
    logic          clear_errors_i;
    logic [N-1:0]  cmd_o;
    logic          busy_o;
    logic [4:0]    active_ch_o;
    logic          timeout_err_o;
    logic [4:0]    err_ch_o;

    always #5 sclk = ~sclk;

    contactor_sequencer dut (
        .sclk           (sclk),
        .rst_n          (rst_n),
        .req_i          (req_i),
        .feedback_i     (feedback_i),
        .shutdown_i     (shutdown_i),
        .clear_errors_i (clear_errors_i),
        .cmd_o          (cmd_o),
        .busy_o         (busy_o),
        .active_ch_o    (active_ch_o),
        .timeout_err_o  (timeout_err_o),
        .err_ch_o       (err_ch_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: an operation is tracked by its age in cycles since the mismatch was seen.
    logic [N-1:0] m_cmd;
    logic         m_err;
    logic [4:0]   m_errch;
    int           m_last, m_ch, age, match_age;
    bit           in_op, in_fault;
    logic         m_tgt;

    // Contactor plant: feedback follows cmd_o after a delay unless stuck.
    logic [N-1:0] pcmd, stuck;
    int           cd [N];
    bit           rand_mode;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        $display("FAIL %s wait bound expired at %0t", name, $time);
    endtask

    task automatic model_reset();
        m_cmd = '0; m_err = 1'b0; m_errch = 5'd0; m_last = N - 1;
        m_ch = 0; m_tgt = 1'b0; age = 0; match_age = -1;
        in_op = 1'b0; in_fault = 1'b0;
    endtask

    function automatic int pick_ch(input logic [N-1:0] req, input logic [N-1:0] cmd, input int last);
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (last + k) % N;
                if (cmd[c] != req[c] && (pass == 1 || cmd[c] == 1'b1)) return c;
            end
        end
        return -1;
    endfunction

    task automatic model_step();
        logic [1:0] fb;
        int c;
        if (!rst_n) begin
            model_reset();
        end else if (shutdown_i) begin
            m_cmd = '0; in_op = 1'b0; in_fault = 1'b0;
            if (clear_errors_i) begin m_err = 1'b0; m_errch = 5'd0; end
        end else if (in_fault) begin
            if (clear_errors_i) begin in_fault = 1'b0; m_err = 1'b0; m_errch = 5'd0; end
        end else if (!in_op) begin
            if (req_i != m_cmd) begin in_op = 1'b1; age = 0; match_age = -1; end
        end else if (age == 0) begin
            c = pick_ch(req_i, m_cmd, m_last);
            if (c < 0) in_op = 1'b0;
            else begin m_ch = c; m_tgt = req_i[c]; age = 1; end
        end else if (age == 1) begin
            m_cmd[m_ch] = m_tgt; age = 2;
        end else if (match_age < 0) begin
            fb = feedback_i[2*m_ch +: 2];
            if ((m_tgt && fb == 2'b10) || (!m_tgt && fb == 2'b01)) begin
                match_age = age; age++;
            end else if (age - 2 == TO - 1) begin
                in_fault = 1'b1; in_op = 1'b0; m_err = 1'b1; m_errch = 5'(m_ch); m_cmd[m_ch] = 1'b0;
            end else age++;
        end else begin
            if (age - match_age == ST) begin in_op = 1'b0; m_last = m_ch; end
            else age++;
        end
    endtask

    task automatic compare_all();
        check("cmd_o", 32'(cmd_o), 32'(m_cmd));
        check("busy_o", 32'(busy_o), 32'(in_op || in_fault));
        check("active_ch_o", 32'(active_ch_o), (in_op && age >= 1) ? m_ch : 0);
        check("timeout_err_o", 32'(timeout_err_o), 32'(m_err));
        check("err_ch_o", 32'(err_ch_o), 32'(m_errch));
    endtask

    task automatic plant_step();
        for (int i = 0; i < N; i++) begin
            if (cmd_o[i] != pcmd[i]) begin
                pcmd[i] = cmd_o[i];
                cd[i] = rand_mode ? int'($urandom_range(0, 6)) : 2;
            end else if (cd[i] > 0) cd[i]--;
        end
    endtask

    task automatic plant_drive();
        for (int i = 0; i < N; i++) begin
            if (stuck[i] || cd[i] > 0) feedback_i[2*i +: 2] = 2'b00;
            else feedback_i[2*i +: 2] = pcmd[i] ? 2'b10 : 2'b01;
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        model_step();
        @(negedge sclk);
        compare_all();
        plant_step();
        plant_drive();
    endtask

    task automatic wait_settled(input string name, input int limit);
        int n;
        n = 0;
        while (!(busy_o == 1'b0 && cmd_o == req_i) && n < limit) begin tick(); n++; end
        if (n >= limit) bound_fail(name);
    endtask

    logic [N-1:0] seen [$];
    logic [N-1:0] prev;

    initial begin
        int n, r;
        rst_n = 1'b0; req_i = '0; shutdown_i = 1'b0; clear_errors_i = 1'b0;
        stuck = '0; pcmd = '0; rand_mode = 1'b0;
        for (int i = 0; i < N; i++) cd[i] = 0;
        plant_drive();
        model_reset();
        repeat (3) tick();
        check("reset_cmd", 32'(cmd_o), 0);
        check("reset_busy", 32'(busy_o), 0);
        check("reset_err", 32'(timeout_err_o), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Close channel 0, feedback arrives 5 cycles after the drive.
        stuck[0] = 1'b1; plant_drive();
        req_i = 21'h000001;
        tick(); tick();
        check("a_cmd_before", 32'(cmd_o), 0);
        tick();
        check("a_cmd_at3", 32'(cmd_o), 1);
        repeat (5) tick();
        stuck[0] = 1'b0; plant_drive();
        repeat (4) tick();
        check("a_busy_settle", 32'(busy_o), 1);
        tick();
        check("a_busy_fall", 32'(busy_o), 0);

        // Opens win, round robin from last_ch+1, close last.
        req_i = 21'h000003;
        wait_settled("b_setup", 100);
        check("b_cmd3", 32'(cmd_o), 3);
        req_i = 21'h000004;
        prev = cmd_o;
        n = 0;
        while (!(busy_o == 1'b0 && cmd_o == req_i) && n < 200) begin
            tick(); n++;
            if (cmd_o != prev) begin seen.push_back(cmd_o); prev = cmd_o; end
        end
        if (n >= 200) bound_fail("b_order");
        check("b_nchg", seen.size(), 3);
        if (seen.size() == 3) begin
            check("b_first", 32'(seen[0]), 32'h2);
            check("b_second", 32'(seen[1]), 32'h0);
            check("b_third", 32'(seen[2]), 32'h4);
        end

        // Channel 20 never confirms.
        stuck[20] = 1'b1; plant_drive();
        req_i = 21'h100004;
        repeat (3) tick();
        check("c_cmd_drive", 32'(cmd_o), 32'h100004);
        repeat (199) tick();
        check("c_err_before", 32'(timeout_err_o), 0);
        tick();
        check("c_err", 32'(timeout_err_o), 1);
        check("c_errch", 32'(err_ch_o), 20);
        check("c_cmd", 32'(cmd_o), 32'h000004);
        repeat (2) tick();
        check("c_hold_busy", 32'(busy_o), 1);
        clear_errors_i = 1'b1; req_i = 21'h000004; stuck[20] = 1'b0; plant_drive();
        tick();
        clear_errors_i = 1'b0;
        check("c_clear_err", 32'(timeout_err_o), 0);
        check("c_clear_idle", 32'(busy_o), 0);

        // Shutdown during the final close.
        req_i = 21'h1FFFFF;
        n = 0;
        while (cmd_o != 21'h1FFFFF && n < 600) begin tick(); n++; end
        if (n >= 600) bound_fail("d_fill");
        check("d_busy_wait", 32'(busy_o), 1);
        shutdown_i = 1'b1;
        tick();
        check("d_cmd_zero", 32'(cmd_o), 0);
        check("d_idle", 32'(busy_o), 0);
        tick();
        check("d_idle_hold", 32'(busy_o), 0);
        req_i = '0; shutdown_i = 1'b0;
        repeat (3) tick();

        // Match arrives on the timeout cycle.
        stuck[3] = 1'b1; plant_drive();
        req_i = 21'h000008;
        repeat (3) tick();
        check("e_cmd", 32'(cmd_o), 8);
        repeat (199) tick();
        stuck[3] = 1'b0; plant_drive();
        tick();
        check("e_no_err", 32'(timeout_err_o), 0);
        check("e_settle_ch", 32'(active_ch_o), 3);
        repeat (3) tick();
        check("e_settle_busy", 32'(busy_o), 1);
        tick();
        check("e_done", 32'(busy_o), 0);

        // Reset in the middle of SETTLE.
        req_i = 21'h000088;
        repeat (7) tick();
        check("f_active", 32'(active_ch_o), 7);
        #2 rst_n = 1'b0;
        model_reset();
        req_i = '0;
        #1;
        compare_all();
        check("f_cmd", 32'(cmd_o), 0);
        check("f_busy", 32'(busy_o), 0);
        check("f_active0", 32'(active_ch_o), 0);
        #1 rst_n = 1'b1;
        repeat (3) tick();

        // Randomised traffic.
        rand_mode = 1'b1;
        for (int t = 0; t < 5000; t++) begin
            if ($urandom_range(0, 11) == 0) begin
                r = int'($urandom_range(0, N - 1));
                req_i[r] = ~req_i[r];
            end
            if (shutdown_i) shutdown_i = ($urandom_range(0, 2) != 0);
            else shutdown_i = ($urandom_range(0, 399) == 0);
            clear_errors_i = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 499) == 0) stuck[$urandom_range(0, N - 1)] = 1'b1;
            if ($urandom_range(0, 59) == 0) stuck = '0;
            plant_drive();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
